// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the pixel generator and checker: state enum and the
// single-step feedback function both ends use.
package lfsr_pkg;

    localparam int MAX_PIXEL_BITS = 8;
    localparam int LFSR_MAX_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } checker_state_t;

    // One shift of a w-bit LFSR carried in a LFSR_MAX_W container; taps 0,2,3,5 feed bit w-1.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] r,
                                                        input int w);
        logic [LFSR_MAX_W-1:0] res;
        logic                  fb;
        fb  = r[0] ^ r[2] ^ r[3] ^ r[5];
        res = r >> 1;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i == w - 1) res[i] = fb;
        end
        return res;
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds on the first word, predicts the rest, counts mismatches.
// Optional reseed after RESYNC_THRESH consecutive mismatches when LFSR_CHECK_RESYNC_EN is defined.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH         = MAX_PIXEL_BITS,
    parameter int ERR_CNT_W     = 16,
    parameter int RESYNC_THRESH = 3
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     stop_code_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic                 locked_o,
    output logic                 error_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic [WIDTH:0]       word_cnt_o,
    output logic                 done_o
);

    localparam int                  STREAK_W = $clog2(RESYNC_THRESH + 1);
    localparam logic [STREAK_W-1:0] THRESH_V = STREAK_W'(RESYNC_THRESH);

    checker_state_t         r_state,     w_state;
    logic [WIDTH-1:0]       r_expected,  w_expected;
    logic [WIDTH-1:0]       r_stop_code, w_stop_code;
    logic [STREAK_W-1:0]    r_streak,    w_streak;
    logic [ERR_CNT_W-1:0]   r_err_count, w_err_count;
    logic [WIDTH:0]         r_word_cnt,  w_word_cnt;
    logic                   r_error,     w_error;
    logic                   r_done,      w_done;
    logic                   r_locked,    w_locked;

    logic [WIDTH-1:0]       w_next_data;
    logic [WIDTH-1:0]       w_next_exp;
    logic [WIDTH:0]         w_cnt_inc;
    logic                   w_last;
    logic                   w_mismatch;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state     = r_state;
        w_expected  = r_expected;
        w_stop_code = r_stop_code;
        w_streak    = r_streak;
        w_err_count = r_err_count;
        w_word_cnt  = r_word_cnt;
        w_error     = 1'b0;

        w_next_data = WIDTH'(lfsr_next(LFSR_MAX_W'(data_i), WIDTH));
        w_next_exp  = WIDTH'(lfsr_next(LFSR_MAX_W'(r_expected), WIDTH));
        w_cnt_inc   = r_word_cnt + (WIDTH+1)'(1);
        w_last      = (w_cnt_inc == ({1'b0, r_stop_code} + (WIDTH+1)'(1)));
        w_mismatch  = (data_i != r_expected);

        if (start_i) begin
            // Start wins over valid_i in every state; a same-cycle word is dropped.
            w_state     = ST_SEED;
            w_stop_code = stop_code_i;
            w_streak    = '0;
            w_err_count = '0;
            w_word_cnt  = '0;
        end else begin
            unique case (r_state)
                ST_SEED: begin
                    if (valid_i) begin
                        w_expected = w_next_data;
                        w_word_cnt = (WIDTH+1)'(1);
                        w_state    = (r_stop_code == '0) ? ST_DONE : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (valid_i) begin
                        w_expected = w_next_exp;
                        w_word_cnt = w_cnt_inc;
                        if (w_mismatch) begin
                            w_error = 1'b1;
                            if (r_err_count != '1) w_err_count = r_err_count + ERR_CNT_W'(1);
`ifdef LFSR_CHECK_RESYNC_EN
                            if (r_streak + STREAK_W'(1) == THRESH_V) begin
                                w_streak   = '0;
                                w_expected = w_next_data;
                            end else begin
                                w_streak = r_streak + STREAK_W'(1);
                            end
`else
                            if (r_streak != THRESH_V) w_streak = r_streak + STREAK_W'(1);
`endif
                        end else begin
                            w_streak = '0;
                        end
                        if (w_last) w_state = ST_DONE;
                    end
                end
                default: ;
            endcase
        end

        w_done   = (w_state == ST_DONE);
        w_locked = (w_state == ST_CHECK) && (w_streak == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            r_state     <= ST_IDLE;
            r_expected  <= '0;
            r_stop_code <= '0;
            r_streak    <= '0;
            r_err_count <= '0;
            r_word_cnt  <= '0;
            r_error     <= 1'b0;
            r_done      <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_expected  <= w_expected;
            r_stop_code <= w_stop_code;
            r_streak    <= w_streak;
            r_err_count <= w_err_count;
            r_word_cnt  <= w_word_cnt;
            r_error     <= w_error;
            r_done      <= w_done;
            r_locked    <= w_locked;
        end
    end

    assign locked_o    = r_locked;
    assign error_o     = r_error;
    assign err_count_o = r_err_count;
    assign word_cnt_o  = r_word_cnt;
    assign done_o      = r_done;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed vector table, hand-written corner
// sequences and randomized streams against a behavioural reference model.
module tb_lfsr_checker;

    localparam int THRESH = 3;

    logic        clk_i = 1'b0;
    logic        nreset_i;
    logic        start_i;
    logic [7:0]  stop_code_i;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        locked_o;
    logic        error_o;
    logic [15:0] err_count_o;
    logic [8:0]  word_cnt_o;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_checker dut (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .start_i     (start_i),
        .stop_code_i (stop_code_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .locked_o    (locked_o),
        .error_o     (error_o),
        .err_count_o (err_count_o),
        .word_cnt_o  (word_cnt_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic [7:0] stop;
        int         n;
        logic [63:0] words;     // word i at [8*i +: 8]
        logic [7:0] err_mask;   // bit i: error_o expected after word i
        int         exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[5];

    // Behavioural model state
    bit         m_seeded, m_done;
    logic [7:0] m_exp, m_stop;
    int         m_cnt, m_err, m_streak;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] r);
        int v, fb;
        v  = int'(r);
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 8'((v >> 1) | (fb << 7));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [7:0] s);
        stop_code_i = s;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        m_seeded = 0; m_done = 0; m_exp = '0; m_stop = s;
        m_cnt = 0; m_err = 0; m_streak = 0;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        valid_i = 1'b0;
        repeat (gap) tick();
        valid_i = 1'b1;
        data_i  = d;
        tick();
        valid_i = 1'b0;
    endtask

    // Model one accepted word; returns whether it should flag an error.
    task automatic model_word(input logic [7:0] d, output bit mis);
        mis = 0;
        if (m_done) return;
        if (!m_seeded) begin
            m_seeded = 1;
            m_exp    = ref_step(d);
            m_cnt    = 1;
        end else begin
            mis = (d != m_exp);
            m_exp = ref_step(m_exp);
            if (mis) begin
                if (m_err < 65535) m_err++;
                m_streak++;
`ifdef LFSR_CHECK_RESYNC_EN
                if (m_streak == THRESH) begin
                    m_streak = 0;
                    m_exp    = ref_step(d);
                end
`else
                if (m_streak > THRESH) m_streak = THRESH;
`endif
            end else begin
                m_streak = 0;
            end
            m_cnt++;
        end
        if (m_cnt == int'(m_stop) + 1) m_done = 1;
    endtask

    task automatic run_vec(input vec_t v, input int gap_max);
        do_start(v.stop);
        for (int i = 0; i < v.n; i++) begin
            send(v.words[8*i +: 8], $urandom_range(0, gap_max));
            check({v.name, " error_o"}, 32'(error_o), 32'(v.err_mask[i]));
            check({v.name, " done_o"}, 32'(done_o), (i == v.n - 1) ? 32'd1 : 32'd0);
        end
        check({v.name, " err_count"}, 32'(err_count_o), 32'(v.exp_err));
        check({v.name, " word_cnt"}, 32'(word_cnt_o), 32'(v.exp_cnt));
    endtask

    initial begin
        bit mis;
        logic [7:0] d;
        int stop;

        nreset_i = 1'b0; start_i = 1'b0; valid_i = 1'b0;
        data_i = '0; stop_code_i = '0;

        vecs[0] = '{"basic",    8'd4, 5, {24'h0, 8'h90, 8'h20, 8'h40, 8'h80, 8'h01}, 8'h00, 0, 5};
        vecs[1] = '{"one_err",  8'd4, 5, {24'h0, 8'h90, 8'h20, 8'h41, 8'h80, 8'h01}, 8'h04, 1, 5};
        vecs[2] = '{"seed_only",8'd0, 1, {56'h0, 8'h5A}, 8'h00, 0, 1};
`ifdef LFSR_CHECK_RESYNC_EN
        vecs[3] = '{"resync",   8'd6, 7, {8'h0, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h01}, 8'h1C, 3, 7};
`else
        vecs[3] = '{"resync",   8'd6, 7, {8'h0, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h01}, 8'h7C, 5, 7};
`endif
        vecs[4] = '{"short_err",8'd1, 2, {48'h0, 8'h56, 8'hAA}, 8'h02, 1, 2};

        repeat (3) tick();
        nreset_i = 1'b1;
        check("rst locked",    32'(locked_o),    0);
        check("rst error",     32'(error_o),     0);
        check("rst err_count", 32'(err_count_o), 0);
        check("rst word_cnt",  32'(word_cnt_o),  0);
        check("rst done",      32'(done_o),      0);

        foreach (vecs[k]) run_vec(vecs[k], 0);
        run_vec(vecs[0], 7);   // gaps between words must not change results
        run_vec(vecs[1], 7);

        // Locked/error timing around a single mismatch
        do_start(8'd4);
        check("seed locked", 32'(locked_o), 0);
        send(8'h01, 0); check("lk after seed", 32'(locked_o), 1);
        send(8'h80, 0); check("lk match", 32'(locked_o), 1);
        send(8'h41, 0); check("lk mismatch", 32'(locked_o), 0);
        check("err pulse", 32'(error_o), 1);
        tick();         check("err pulse end", 32'(error_o), 0);
        check("lk idle gap", 32'(locked_o), 0);
        send(8'h20, 0); check("lk recover", 32'(locked_o), 1);
        send(8'h90, 0); check("lk done", 32'(locked_o), 0);
        send(8'h12, 0);
        check("done ignores cnt", 32'(word_cnt_o), 5);
        check("done ignores err", 32'(err_count_o), 1);
        check("done held", 32'(done_o), 1);

        // Reset mid-operation
        do_start(8'd4);
        send(8'h01, 0); send(8'h55, 0);
        nreset_i = 1'b0; tick(); nreset_i = 1'b1;
        check("midrst err_count", 32'(err_count_o), 0);
        check("midrst word_cnt",  32'(word_cnt_o),  0);
        check("midrst locked",    32'(locked_o),    0);
        send(8'h01, 0);
        check("idle ignores valid", 32'(word_cnt_o), 0);
        run_vec(vecs[0], 2);

        // Start mid-CHECK with a same-cycle word that must be dropped
        do_start(8'd4);
        send(8'h01, 0); send(8'h80, 0); send(8'h33, 0);
        stop_code_i = 8'd4; start_i = 1'b1; valid_i = 1'b1; data_i = 8'h77;
        tick();
        start_i = 1'b0; valid_i = 1'b0;
        check("restart word_cnt",  32'(word_cnt_o),  0);
        check("restart err_count", 32'(err_count_o), 0);
        check("restart done",      32'(done_o),      0);
        for (int i = 0; i < 5; i++) send(vecs[0].words[8*i +: 8], 0);
        check("restart final err", 32'(err_count_o), 0);
        check("restart final cnt", 32'(word_cnt_o), 5);
        check("restart final done", 32'(done_o), 1);

        // Randomized streams against the model
        for (int r = 0; r < 40; r++) begin
            stop = $urandom_range(0, 12);
            do_start(8'(stop));
            while (!m_done) begin
                d = m_seeded ? m_exp : 8'($urandom_range(0, 255));
                if (m_seeded && $urandom_range(0, 3) == 0) d = d ^ 8'($urandom_range(1, 255));
                send(d, $urandom_range(0, 3));
                model_word(d, mis);
                check("rnd error_o",   32'(error_o), 32'(mis));
                check("rnd locked_o",  32'(locked_o), 32'(!m_done && m_streak == 0));
                check("rnd err_count", 32'(err_count_o), 32'(m_err));
                check("rnd word_cnt",  32'(word_cnt_o), 32'(m_cnt));
                check("rnd done_o",    32'(done_o), 32'(m_done));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
